ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ACCESS_CYCLES, default 2, giving the number of cycles enRAM is held per access (legal range 1..15).
REQ-002 The block SHALL have parameter RW_WRITE, default 1'b1, giving the ram_RW level that means write; the opposite level means read.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; qualified by the matching req.
REQ-007 addr0, addr1  input  8 each  RAM address for each requester.
REQ-008 wdata0, wdata1  input  8 each  write data for each requester.
REQ-009 gnt0, gnt1  output  1 each  requester owns the RAM; one-hot or zero.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse.
REQ-011 rdata  output  8  read data of the last completed read.
REQ-012 ram_address  output  8  to RAM address.
REQ-013 ram_in  output  8  to RAM write data.
REQ-014 ram_enRAM  output  1  RAM enable.
REQ-015 ram_RW  output  1  RAM read/write select.
REQ-016 ram_out  input  8  RAM read data.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS and DONE; all outputs SHALL be registered.
REQ-018 IDLE: when req0 or req1 is high at a clk edge, the block SHALL arbitrate, latch the winner's we/addr/wdata, set its gnt, and enter ACCESS on that edge.
REQ-019 Arbitration SHALL be round-robin: a lone requester wins; on a tie, the requester not served last wins; the last-served pointer updates on grant.
REQ-020 ACCESS: ram_enRAM=1, ram_address=latched addr, ram_in=latched wdata, ram_RW=RW_WRITE if write else ~RW_WRITE, held constant for exactly ACCESS_CYCLES cycles; a cycle counter SHALL count 0..ACCESS_CYCLES-1.
REQ-021 On the edge ending the last ACCESS cycle of a read, rdata SHALL capture ram_out; writes SHALL leave rdata unchanged.
REQ-022 On that same edge the state SHALL go to DONE, ram_enRAM SHALL go 0, and the granted requester's done SHALL be high for exactly the DONE cycle.
REQ-023 gnt SHALL stay high from the first ACCESS cycle through the DONE cycle and drop on exit from DONE to IDLE.
REQ-024 Latency: req sampled at edge k -> gnt high from k, ram_enRAM high cycles k..k+ACCESS_CYCLES-1, done high in cycle k+ACCESS_CYCLES, next grant possible at edge k+ACCESS_CYCLES+1.
REQ-025 Inputs (req, we, addr, wdata) SHALL be ignored outside IDLE; deasserting req mid-transaction SHALL NOT abort it.
REQ-026 A req still high in IDLE after its done SHALL be treated as a new request; requesters drop req in the done cycle to avoid reissue.
REQ-027 ram_address, ram_in and ram_RW SHALL hold their last values while ram_enRAM=0.
REQ-028 gnt0&gnt1 and done0&done1 SHALL never be high together.

Reset
REQ-029 reset high SHALL immediately force state IDLE, counter 0, gnt0/gnt1/done0/done1/ram_enRAM=0, ram_address/ram_in/rdata=8'h00, ram_RW=~RW_WRITE, last-served=1 (requester 0 wins the first tie).
REQ-030 Reset during ACCESS SHALL abort the transaction with no done pulse and no rdata update.

Verification
REQ-031 Write then read: req0, we0=1, addr0=8'h3C, wdata0=8'hA5 -> ram_enRAM high 2 cycles with ram_RW=1, done0 pulse; then req0 read 8'h3C -> rdata=8'hA5 in the done0 cycle.
REQ-032 Tie after reset: req0=req1=1 -> gnt0 first; req1 held -> gnt1 immediately after done0; a repeated tie then alternates 0,1,0,1.
REQ-033 Input change: req1 read at 8'h10, then addr1 changed to 8'h20 and req1 dropped during ACCESS -> ram_address stays 8'h10 and done1 still pulses.
REQ-034 Reset mid-access: assert reset in ACCESS cycle 1 -> ram_enRAM=0 and gnt=0 at once, no done, rdata=8'h00.
REQ-035 ACCESS_CYCLES=1: single read -> ram_enRAM high 1 cycle, done in the following cycle, back-to-back accesses 2 cycles apart.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Each granted access holds the RAM enable for ACCESS_CYCLES cycles, then
// pulses the winner's done for one cycle. The edge that ends the DONE cycle
// may grant again, so a waiting requester loses no cycle.
module ram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic        RW_WRITE      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic [7:0] ram_address,
  output logic [7:0] ram_in,
  output logic       ram_enRAM,
  output logic       ram_RW,
  input  logic [7:0] ram_out
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic       done0_q, done0_d, done1_q, done1_d;
  logic       en_q, en_d, rw_q, rw_d, we_q, we_d;
  logic       last_q, last_d;  // index of the requester served most recently
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic pick1;
  logic start;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1 = req1 & (~req0 | ~last_q);
  // A new transaction may start from IDLE or on the edge that ends DONE.
  assign start = ((state_q == StIdle) || (state_q == StDone)) && (req0 || req1);

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= ~RW_WRITE;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: access sequencing, then grant override when starting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = done0_q;
    done1_d = done1_q;
    en_d    = en_q;
    rw_d    = rw_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
      end
      StAccess: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          en_d    = 1'b0;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          if (!we_q) rdata_d = ram_out;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d = StAccess;
      cnt_d   = 4'd0;
      gnt0_d  = ~pick1;
      gnt1_d  = pick1;
      last_d  = pick1;
      en_d    = 1'b1;
      we_d    = pick1 ? we1 : we0;
      addr_d  = pick1 ? addr1 : addr0;
      wdata_d = pick1 ? wdata1 : wdata0;
      rw_d    = (pick1 ? we1 : we0) ? RW_WRITE : ~RW_WRITE;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata       = rdata_q;
  assign ram_address = addr_q;
  assign ram_in      = wdata_q;
  assign ram_enRAM   = en_q;
  assign ram_RW      = rw_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (2-cycle/write-high and
// 1-cycle/write-low) share stimulus, each with its own RAM and a
// transaction-timeline reference model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic ram_init;

  logic g0_a, g1_a, d0_a, d1_a, en_a, rw_a;
  logic [7:0] rd_a, adr_a, din_a, rout_a;
  logic g0_b, g1_b, d0_b, d1_b, en_b, rw_b;
  logic [7:0] rd_b, adr_b, din_b, rout_b;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ACCESS_CYCLES(2), .RW_WRITE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(g0_a), .gnt1(g1_a), .done0(d0_a), .done1(d1_a), .rdata(rd_a),
    .ram_address(adr_a), .ram_in(din_a), .ram_enRAM(en_a), .ram_RW(rw_a), .ram_out(rout_a)
  );

  ram_arbiter #(.ACCESS_CYCLES(1), .RW_WRITE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(g0_b), .gnt1(g1_b), .done0(d0_b), .done1(d1_b), .rdata(rd_b),
    .ram_address(adr_b), .ram_in(din_b), .ram_enRAM(en_b), .ram_RW(rw_b), .ram_out(rout_b)
  );

  // Behavioural RAMs, asynchronous read.
  assign rout_a = ram_a[adr_a];
  assign rout_b = ram_b[adr_b];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) begin
        ram_a[k] <= 8'(k * 7 + 3);
        ram_b[k] <= 8'(k * 7 + 3);
      end
    end else begin
      if (en_a && rw_a == 1'b1) ram_a[adr_a] <= din_a;
      if (en_b && rw_b == 1'b0) ram_b[adr_b] <= din_b;
    end
  end

  // Reference model: a transaction is "busy" for ac+1 cycles after its grant
  // edge (t = 0..ac-1 enable, t = ac done).
  int         ac  [2] = '{2, 1};
  bit         rww [2] = '{1'b1, 1'b0};
  bit         m_busy [2];
  int         m_t    [2];
  bit         m_who  [2];
  bit         m_last [2];
  bit         m_we   [2];
  logic       m_rw   [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wdata[2];
  logic [7:0] m_rdata[2];
  logic [7:0] m_mem  [2][256];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_busy[i]  = 1'b0;
    m_t[i]     = 0;
    m_who[i]   = 1'b0;
    m_last[i]  = 1'b1;
    m_we[i]    = 1'b0;
    m_rw[i]    = ~rww[i];
    m_addr[i]  = 8'h00;
    m_wdata[i] = 8'h00;
    m_rdata[i] = 8'h00;
  endtask

  task automatic model_step(input int i);
    bit free;
    bit w;
    bit wr;
    if (reset) return;
    free = !m_busy[i] || (m_t[i] == ac[i]);
    if (m_busy[i]) begin
      if (m_t[i] < ac[i]) begin
        if (m_we[i]) m_mem[i][m_addr[i]] = m_wdata[i];
        else if (m_t[i] == ac[i] - 1) m_rdata[i] = m_mem[i][m_addr[i]];
        m_t[i]++;
      end else begin
        m_busy[i] = 1'b0;
      end
    end
    if (free && (req0 || req1)) begin
      w          = (req0 && req1) ? ~m_last[i] : req1;
      wr         = w ? we1 : we0;
      m_last[i]  = w;
      m_who[i]   = w;
      m_busy[i]  = 1'b1;
      m_t[i]     = 0;
      m_we[i]    = wr;
      m_addr[i]  = w ? addr1 : addr0;
      m_wdata[i] = w ? wdata1 : wdata0;
      m_rw[i]    = wr ? rww[i] : ~rww[i];
    end
  endtask

  task automatic check_outs(input int i, input logic g0, input logic g1, input logic d0,
                            input logic d1, input logic en, input logic [7:0] ad,
                            input logic [7:0] di, input logic rw, input logic [7:0] rd);
    logic eg0, eg1, ed0, ed1, een;
    eg0 = m_busy[i] && !m_who[i];
    eg1 = m_busy[i] && m_who[i];
    ed0 = eg0 && (m_t[i] == ac[i]);
    ed1 = eg1 && (m_t[i] == ac[i]);
    een = m_busy[i] && (m_t[i] < ac[i]);
    check_eq($sformatf("i%0d_gnt0", i), {7'd0, g0}, {7'd0, eg0});
    check_eq($sformatf("i%0d_gnt1", i), {7'd0, g1}, {7'd0, eg1});
    check_eq($sformatf("i%0d_done0", i), {7'd0, d0}, {7'd0, ed0});
    check_eq($sformatf("i%0d_done1", i), {7'd0, d1}, {7'd0, ed1});
    check_eq($sformatf("i%0d_en", i), {7'd0, en}, {7'd0, een});
    check_eq($sformatf("i%0d_addr", i), ad, m_addr[i]);
    check_eq($sformatf("i%0d_wdata", i), di, m_wdata[i]);
    check_eq($sformatf("i%0d_rw", i), {7'd0, rw}, {7'd0, m_rw[i]});
    check_eq($sformatf("i%0d_rdata", i), rd, m_rdata[i]);
    check_eq($sformatf("i%0d_gnt_excl", i), {7'd0, g0 & g1}, 8'd0);
    check_eq($sformatf("i%0d_done_excl", i), {7'd0, d0 & d1}, 8'd0);
  endtask

  task automatic check_all();
    check_outs(0, g0_a, g1_a, d0_a, d1_a, en_a, adr_a, din_a, rw_a, rd_a);
    check_outs(1, g0_b, g1_b, d0_b, d1_b, en_b, adr_b, din_b, rw_b, rd_b);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Bounded wait for done0/done1 of the 2-cycle instance.
  task automatic wait_done(input string tag, input int which);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      cycle();
      seen = (which == 0) ? d0_a : d1_a;
    end
    check_eq(tag, {7'd0, seen}, 8'd1);
  endtask

  initial begin
    bit prev_en;
    bit order [$];

    reset = 1'b1; ram_init = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int k = 0; k < 256; k++) begin
      m_mem[0][k] = 8'(k * 7 + 3);
      m_mem[1][k] = 8'(k * 7 + 3);
    end
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    @(posedge clk);
    #1;
    ram_init = 1'b0;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Held tie from reset: grants must alternate starting with requester 0.
    req0 = 1; req1 = 1; addr0 = 8'h01; addr1 = 8'h02;
    prev_en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (en_a && !prev_en) order.push_back(g1_a);
      prev_en = en_a;
    end
    check_eq("tie_count", {7'd0, order.size() >= 4}, 8'd1);
    for (int k = 0; k < 4 && k < order.size(); k++)
      check_eq($sformatf("tie_order%0d", k), {7'd0, order[k]}, 8'(k % 2));
    req0 = 0; req1 = 0;
    repeat (5) cycle();

    // Write A5 to 3C, then read it back.
    req0 = 1; we0 = 1; addr0 = 8'h3C; wdata0 = 8'hA5;
    cycle();
    req0 = 0;
    wait_done("wr_done0", 0);
    req0 = 1; we0 = 0;
    cycle();
    req0 = 0;
    wait_done("rd_done0", 0);
    check_eq("rd_a5_a", rd_a, 8'hA5);
    check_eq("rd_a5_b", rd_b, 8'hA5);
    cycle();

    // Inputs change mid-access must be ignored.
    req1 = 1; we1 = 0; addr1 = 8'h10;
    cycle();
    addr1 = 8'h20; req1 = 0;
    wait_done("chg_done1", 1);
    check_eq("chg_addr", adr_a, 8'h10);
    cycle();

    // Reset during the second access cycle.
    req0 = 1; we0 = 0; addr0 = 8'h3C;
    cycle();
    req0 = 0;
    cycle();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_en", {7'd0, en_a}, 8'd0);
    check_eq("rst_gnt", {7'd0, g0_a | g1_a}, 8'd0);
    check_eq("rst_rdata", rd_a, 8'h00);
    model_reset(0);
    model_reset(1);
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) cycle();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        pulse_reset();
      end else begin
        req0   = ($urandom_range(0, 9) < 4);
        req1   = ($urandom_range(0, 9) < 4);
        we0    = 1'($urandom_range(0, 1));
        we1    = 1'($urandom_range(0, 1));
        addr0  = 8'($urandom_range(0, 15));
        addr1  = 8'($urandom_range(0, 15));
        wdata0 = 8'($urandom);
        wdata1 = 8'($urandom);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
